fft_input_loader: RTL and testbench

Serial-to-parallel, double-buffered sample loader that sits directly upstream of `stage1` in the 32-point radix-2 FFT. It accepts one 8-bit two's-complement time-domain sample per cycle under a valid/ready handshake and assembles 32 consecutive samples into a frame. It then presents the frame in natural order on `X0..X31`, which are wired straight to `stage1` (which performs the bit-reversed pairing and sign extension itself). It holds the frame stable until the FFT controller acknowledges it. A second bank fills while the first is being consumed.

---
 rtl/fft_input_loader.sv | 149 ++++++++++++++
 tb/tb_fft_input_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// Double-buffered serial-to-parallel loader: gathers 32 samples per bank and
// presents a completed bank on X0..X31 until the FFT controller acknowledges it.
module fft_input_loader #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_MAC,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              frame_ack,
    output logic              frame_valid,
    output logic              frame_start,
    output logic [DATA_W-1:0] X0,
    output logic [DATA_W-1:0] X1,
    output logic [DATA_W-1:0] X2,
    output logic [DATA_W-1:0] X3,
    output logic [DATA_W-1:0] X4,
    output logic [DATA_W-1:0] X5,
    output logic [DATA_W-1:0] X6,
    output logic [DATA_W-1:0] X7,
    output logic [DATA_W-1:0] X8,
    output logic [DATA_W-1:0] X9,
    output logic [DATA_W-1:0] X10,
    output logic [DATA_W-1:0] X11,
    output logic [DATA_W-1:0] X12,
    output logic [DATA_W-1:0] X13,
    output logic [DATA_W-1:0] X14,
    output logic [DATA_W-1:0] X15,
    output logic [DATA_W-1:0] X16,
    output logic [DATA_W-1:0] X17,
    output logic [DATA_W-1:0] X18,
    output logic [DATA_W-1:0] X19,
    output logic [DATA_W-1:0] X20,
    output logic [DATA_W-1:0] X21,
    output logic [DATA_W-1:0] X22,
    output logic [DATA_W-1:0] X23,
    output logic [DATA_W-1:0] X24,
    output logic [DATA_W-1:0] X25,
    output logic [DATA_W-1:0] X26,
    output logic [DATA_W-1:0] X27,
    output logic [DATA_W-1:0] X28,
    output logic [DATA_W-1:0] X29,
    output logic [DATA_W-1:0] X30,
    output logic [DATA_W-1:0] X31
);

    localparam int unsigned DEPTH = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] bank_q [2][DEPTH];
    logic [DATA_W-1:0] bank_d [2][DEPTH];
    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              frame_start_q, frame_start_d;
    logic              accept;
    logic              ack_take;

    // Handshake flags depend on registers only, never on in_valid.
    assign in_ready    = !bank_full_q[wr_bank_q];
    assign frame_valid = bank_full_q[rd_bank_q];
    assign frame_start = frame_start_q;

    always_comb begin
        bank_d        = bank_q;
        bank_full_d   = bank_full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_ptr_d      = wr_ptr_q;
        accept        = in_valid && in_ready;
        ack_take      = frame_ack && frame_valid;

        if (accept) begin
            bank_d[wr_bank_q][wr_ptr_q] = in_data;
            wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
            end
        end

        // Completion and release never hit the same bank, so both may apply.
        if (ack_take) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = !rd_bank_q;
        end

        // Pulse whenever the presented bank becomes a newly completed one.
        frame_start_d = bank_full_d[rd_bank_d] && (!frame_valid || ack_take);
    end

    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
            bank_full_q   <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            bank_full_q   <= bank_full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign X0  = bank_q[rd_bank_q][0];
    assign X1  = bank_q[rd_bank_q][1];
    assign X2  = bank_q[rd_bank_q][2];
    assign X3  = bank_q[rd_bank_q][3];
    assign X4  = bank_q[rd_bank_q][4];
    assign X5  = bank_q[rd_bank_q][5];
    assign X6  = bank_q[rd_bank_q][6];
    assign X7  = bank_q[rd_bank_q][7];
    assign X8  = bank_q[rd_bank_q][8];
    assign X9  = bank_q[rd_bank_q][9];
    assign X10 = bank_q[rd_bank_q][10];
    assign X11 = bank_q[rd_bank_q][11];
    assign X12 = bank_q[rd_bank_q][12];
    assign X13 = bank_q[rd_bank_q][13];
    assign X14 = bank_q[rd_bank_q][14];
    assign X15 = bank_q[rd_bank_q][15];
    assign X16 = bank_q[rd_bank_q][16];
    assign X17 = bank_q[rd_bank_q][17];
    assign X18 = bank_q[rd_bank_q][18];
    assign X19 = bank_q[rd_bank_q][19];
    assign X20 = bank_q[rd_bank_q][20];
    assign X21 = bank_q[rd_bank_q][21];
    assign X22 = bank_q[rd_bank_q][22];
    assign X23 = bank_q[rd_bank_q][23];
    assign X24 = bank_q[rd_bank_q][24];
    assign X25 = bank_q[rd_bank_q][25];
    assign X26 = bank_q[rd_bank_q][26];
    assign X27 = bank_q[rd_bank_q][27];
    assign X28 = bank_q[rd_bank_q][28];
    assign X29 = bank_q[rd_bank_q][29];
    assign X30 = bank_q[rd_bank_q][30];
    assign X31 = bank_q[rd_bank_q][31];

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized self-checking bench for fft_input_loader against a frame-queue
// reference model (completed frames in order, head frame is the presented one).
module tb_fft_input_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NS     = 32;

    logic              clk_MAC = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              frame_ack = 1'b0;
    logic              in_ready;
    logic              frame_valid;
    logic              frame_start;
    logic [DATA_W-1:0] x_obs [NS];

    int checks = 0;
    int errors = 0;

    typedef logic [NS*DATA_W-1:0] frame_t;
    frame_t fq[$];
    int     id_q[$];
    frame_t part;
    int     part_cnt;
    int     next_id;
    int     prev_head;
    logic   exp_start;
    logic   last_acc;

    fft_input_loader #(.DATA_W(DATA_W)) dut (
        .clk_MAC(clk_MAC), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .frame_ack(frame_ack), .frame_valid(frame_valid),
        .frame_start(frame_start),
        .X0(x_obs[0]),   .X1(x_obs[1]),   .X2(x_obs[2]),   .X3(x_obs[3]),
        .X4(x_obs[4]),   .X5(x_obs[5]),   .X6(x_obs[6]),   .X7(x_obs[7]),
        .X8(x_obs[8]),   .X9(x_obs[9]),   .X10(x_obs[10]), .X11(x_obs[11]),
        .X12(x_obs[12]), .X13(x_obs[13]), .X14(x_obs[14]), .X15(x_obs[15]),
        .X16(x_obs[16]), .X17(x_obs[17]), .X18(x_obs[18]), .X19(x_obs[19]),
        .X20(x_obs[20]), .X21(x_obs[21]), .X22(x_obs[22]), .X23(x_obs[23]),
        .X24(x_obs[24]), .X25(x_obs[25]), .X26(x_obs[26]), .X27(x_obs[27]),
        .X28(x_obs[28]), .X29(x_obs[29]), .X30(x_obs[30]), .X31(x_obs[31])
    );

    always #5 clk_MAC = ~clk_MAC;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic frame_t pack_obs();
        frame_t v;
        for (int k = 0; k < NS; k++) v[k*DATA_W +: DATA_W] = x_obs[k];
        return v;
    endfunction

    task automatic model_reset();
        fq.delete();
        id_q.delete();
        part      = '0;
        part_cnt  = 0;
        prev_head = -1;
        exp_start = 1'b0;
        last_acc  = 1'b0;
    endtask

    // One rising edge: release the head frame on ack, append the sample on accept.
    task automatic model_edge();
        logic acc;
        logic ak;
        int   head;
        acc = in_valid && (fq.size() < 2);
        ak  = frame_ack && (fq.size() > 0);
        if (ak) begin
            void'(fq.pop_front());
            void'(id_q.pop_front());
        end
        if (acc) begin
            part[part_cnt*DATA_W +: DATA_W] = in_data;
            part_cnt++;
            if (part_cnt == NS) begin
                fq.push_back(part);
                id_q.push_back(next_id);
                next_id++;
                part_cnt = 0;
            end
        end
        head      = (id_q.size() > 0) ? id_q[0] : -1;
        exp_start = (head >= 0) && (head != prev_head);
        prev_head = head;
        last_acc  = acc;
    endtask

    task automatic check_outputs();
        check_eq("in_ready", in_ready, fq.size() < 2);
        check_eq("frame_valid", frame_valid, fq.size() > 0);
        check_eq("frame_start", frame_start, exp_start);
        if (fq.size() > 0) check_eq("X", pack_obs(), fq[0]);
    endtask

    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ack);
        @(negedge clk_MAC);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        frame_ack = ack;
        @(posedge clk_MAC);
        model_edge();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #3;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        rst       = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_frame_valid", frame_valid, 1'b0);
        check_eq("rst_frame_start", frame_start, 1'b0);
        check_eq("rst_X", pack_obs(), '0);
        model_reset();
        @(negedge clk_MAC);
        rst = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] bnd [NS];
        logic [DATA_W-1:0] pend;
        int sent;
        next_id = 0;
        model_reset();

        // Single frame 0..31, then a boundary frame with -128 and 127.
        do_reset();
        for (int k = 0; k < NS; k++) cycle(1'b1, DATA_W'(k), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        for (int k = 0; k < NS; k++) bnd[k] = DATA_W'($urandom);
        bnd[0]  = 8'h80;
        bnd[31] = 8'h7F;
        bnd[15] = 8'h80;
        for (int k = 0; k < NS; k++) cycle(1'b1, bnd[k], 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Backpressure: 70 valid cycles, no ack, then ack with source still holding.
        do_reset();
        sent = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, DATA_W'(sent), 1'b0);
            if (last_acc) sent++;
        end
        cycle(1'b1, DATA_W'(sent), 1'b1);
        if (last_acc) sent++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DATA_W'(sent), 1'b0);
            if (last_acc) sent++;
        end

        // Ack of bank 0 on the same edge that sample 63 completes bank 1.
        do_reset();
        for (int k = 0; k < 63; k++) cycle(1'b1, DATA_W'(k), 1'b0);
        cycle(1'b1, DATA_W'(63), 1'b1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        // Gapped input with acks issued only while nothing is presented.
        do_reset();
        sent = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(i[0] == 1'b0, DATA_W'(sent + 100), fq.size() == 0);
            if (last_acc) sent++;
        end

        // Reset with bank 0 full and 20 samples in bank 1, then a fresh frame.
        do_reset();
        for (int k = 0; k < 52; k++) cycle(1'b1, DATA_W'(k + 7), 1'b0);
        do_reset();
        for (int k = 0; k < NS; k++) cycle(1'b1, DATA_W'(200 + k), 1'b0);
        cycle(1'b0, '0, 1'b0);

        // Random traffic with held samples under backpressure.
        do_reset();
        pend = DATA_W'($urandom);
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, pend, $urandom_range(0, 9) < 2);
            if (last_acc) pend = DATA_W'($urandom);
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
